// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
//
// Ports:
//   clk    : destination clock, rising edge
//   rst_p  : asynchronous active-high reset, clears both stages to 0
//   d      : asynchronous input
//   q      : input resynchronized to clk (two-cycle latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_p,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - push-button debouncer with press/release pulses
//
// Ports:
//   clk           : system clock, rising edge
//   rst_p         : asynchronous active-high reset
//   btn_in        : raw bouncy button, asynchronous to clk
//   btn_level     : debounced level, registered
//   press_pulse   : one-cycle pulse when a press is accepted (counter enable)
//   release_pulse : one-cycle pulse when a release is accepted
//
// A level change is accepted only after the synchronized input has held the
// new value for STABLE_CYCLES cycles inside the matching WAIT state; any
// opposite sample falls back to the previous stable state.
module btn_debounce_pulse #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic rst_p,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] WAIT_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_p (rst_p),
    .d     (btn_in),
    .q     (sync)
  );

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // Pulses are single-cycle: cleared unless set again below.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= WAIT_PRESS;
            cnt   <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!sync) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync) begin
            state <= WAIT_RELEASE;
            cnt   <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (sync) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
